lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. It consumes the execute stage's memory address, byte index, store data and register-writeback fields.
- For loads and stores it runs a req/ack transaction on the data bus. It does byte-lane steering and sign/zero extension, and produces registered writeback fields for the register file.
- It stalls the pipeline while a bus access is outstanding. Non-memory instructions pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles bus_req_o may wait for bus_ack_i before aborting. Range 1..255; counter is 8 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- valid_i  in  1  execute stage presents an instruction this cycle
- mem_rd_i  in  1  instruction is a load
- mem_we_i  in  1  instruction is a store (mem_rd_i and mem_we_i are never both 1)
- size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- unsigned_i  in  1  zero-extend load (LBU/LHU)
- addr_i  in  32  effective address (reg1 + imm)
- index_i  in  2  byte index, equal to addr_i[1:0]
- store_data_i  in  32  rs2 data
- reg_wdata_i  in  32  ALU result for non-memory instructions
- reg_we_i  in  1  writeback enable
- reg_waddr_i  in  5  writeback register
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_ack_i  in  1  bus completion; rdata is valid in the same cycle
- bus_rdata_i  in  32  read word
- wb_we_o  out  1  writeback enable (registered)
- wb_waddr_o  out  5  writeback register (registered)
- wb_wdata_o  out  32  writeback data (registered)
- hold_flag_o  out  1  stall request to ctrl (combinational)
- misalign_o  out  1  one-cycle pulse: misaligned access rejected
- bus_err_o  out  1  one-cycle pulse: bus timeout

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs are 0, including bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, wb_*, misalign_o and bus_err_o. The timeout counter is 0.
- Reset mid-transaction: the access is abandoned. bus_req_o is 0 from the next cycle, there is no writeback and no error pulse.
- FSM states: IDLE and BUS.
- IDLE, valid_i=1, not a memory op: on the next edge wb_* <= {reg_we_i, reg_waddr_i, reg_wdata_i}. One-cycle latency; stays in IDLE.
- IDLE, valid_i=0: on the next edge wb_we_o <= 0.
- Misalignment rules:
  - Half access with index_i[0]=1 is misaligned.
  - Word access with index_i!=0 is misaligned.
  - Byte access is never misaligned.
- IDLE, misaligned memory op: no bus access. misalign_o=1 for one cycle (registered), wb_we_o <= 0, stays in IDLE, hold not asserted.
- IDLE, aligned memory op: latch the op fields and go to BUS. bus_req_o=1 from the next cycle. Counter cleared.
- Store lane steering:
  - byte: be = 4'b0001 << index, wdata = {4{store_data[7:0]}}.
  - half: be = 4'b0011 << index, wdata = {2{store_data[15:0]}}.
  - word: be = 4'b1111, wdata = store_data.
- Loads: be is computed with the same rule; bus_we_o=0.
- BUS, bus_ack_i=0: hold bus outputs stable and increment the counter.
  - When the counter reaches TIMEOUT_CYCLES, the next edge gives: bus_req_o=0, bus_err_o=1 for one cycle, wb_we_o=0, state IDLE.
- BUS, bus_ack_i=1: the next edge gives: bus_req_o=0, state IDLE.
  - Load: wb_we_o = latched reg_we, wb_waddr_o = latched waddr. wb_wdata_o = extracted value:
    - byte = rdata[8*idx+:8]; half = rdata[8*idx+:16]; word = rdata.
    - Sign-extended unless unsigned.
  - Store: wb_we_o=0.
- An ack arriving in the same cycle the counter hits the limit counts as an ack; no error.
- hold_flag_o = (IDLE & valid_i & aligned mem op) | (BUS & ~bus_ack_i). It deasserts in the ack cycle so execute advances on that edge.
- Timeout cycle: hold_flag_o stays 1 in the cycle the counter reaches the limit. It drops the following cycle.
- valid_i is ignored while in BUS.
- bus_ack_i is ignored in IDLE.
- Writes to x0 are passed through; the register file discards them.

Test Plan:
- Pass-through: valid_i=1, non-memory op, reg_wdata_i=0x1234, waddr=5, we=1 -> next cycle wb_we_o=1, wb_waddr_o=5, wb_wdata_o=0x1234; hold_flag_o never 1.
- LB signed: addr=0x1003, ack after 2 wait cycles, rdata=0x80FF_0000 -> bus_addr_o=0x1000, bus_be_o=4'b1000; hold high for 3 cycles; wb_wdata_o=0xFFFF_FF80. Repeat with unsigned_i=1 -> wb_wdata_o=0x0000_0080.
- SH: addr=0x2002, store_data=0xDEAD_BEEF, immediate ack -> bus_we_o=1, bus_be_o=4'b1100, bus_wdata_o=0xBEEF_BEEF; wb_we_o=0.
- Misalign: LW addr=0x3001 -> bus_req_o stays 0; misalign_o pulses once; wb_we_o=0. LH addr=0x3003 behaves the same.
- Timeout: TIMEOUT_CYCLES=4, LW with no ack -> bus_req_o high 5 cycles, then bus_err_o pulses once; state returns to IDLE. A following pass-through instruction completes normally.
- Reset mid-op: rst_n=0 while in BUS -> next cycle all outputs 0; a later ack is ignored; no writeback.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: runs a req/ack data-bus access for loads/stores, steers byte lanes,
// extends load data and registers the writeback fields; stalls execute while the bus is busy.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic        mem_rd_i,
   input  logic        mem_we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [1:0]  index_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        wb_we_o,
   output logic [4:0]  wb_waddr_o,
   output logic [31:0] wb_wdata_o,
   output logic        hold_flag_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic {IDLE, BUS} state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state;
   logic [7:0]  timeout_cnt;
   logic        op_load;
   logic        op_unsigned;
   logic        op_reg_we;
   logic [4:0]  op_waddr;
   logic [1:0]  op_size;
   logic [1:0]  op_index;

   logic        mem_op;
   logic        misaligned;
   logic [3:0]  store_be;
   logic [31:0] store_wdata;
   logic [31:0] lane;
   logic [31:0] load_data;

   // The lane index arrives separately as index_i; the low address bits are redundant.
   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^addr_i[1:0];

   assign mem_op = mem_rd_i | mem_we_i;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      misaligned  = 1'b0;
      store_be    = 4'b1111;
      store_wdata = store_data_i;
      case (size_i)
         2'b00: begin
            store_be    = 4'b0001 << index_i;
            store_wdata = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            misaligned  = index_i[0];
            store_be    = 4'b0011 << index_i;
            store_wdata = {2{store_data_i[15:0]}};
         end
         default: misaligned = (index_i != 2'b00);
      endcase
   end

   always_comb begin
      lane      = bus_rdata_i >> {op_index, 3'b000};
      load_data = bus_rdata_i;
      case (op_size)
         2'b00:   load_data = {{24{~op_unsigned & lane[7]}}, lane[7:0]};
         2'b01:   load_data = {{16{~op_unsigned & lane[15]}}, lane[15:0]};
         default: load_data = bus_rdata_i;
      endcase
   end

   // Drops in the ack cycle so execute advances on the same edge the access retires.
   assign hold_flag_o = (state == IDLE) ? (valid_i & mem_op & ~misaligned) : ~bus_ack_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         timeout_cnt <= 8'd0;
         op_load     <= 1'b0;
         op_unsigned <= 1'b0;
         op_reg_we   <= 1'b0;
         op_waddr    <= 5'd0;
         op_size     <= 2'b00;
         op_index    <= 2'b00;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= 32'd0;
         bus_be_o    <= 4'd0;
         bus_wdata_o <= 32'd0;
         wb_we_o     <= 1'b0;
         wb_waddr_o  <= 5'd0;
         wb_wdata_o  <= 32'd0;
         misalign_o  <= 1'b0;
         bus_err_o   <= 1'b0;
      end else begin
         wb_we_o    <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  if (!mem_op) begin
                     wb_we_o    <= reg_we_i;
                     wb_waddr_o <= reg_waddr_i;
                     wb_wdata_o <= reg_wdata_i;
                  end else if (misaligned) begin
                     misalign_o <= 1'b1;
                  end else begin
                     state       <= BUS;
                     timeout_cnt <= 8'd0;
                     op_load     <= mem_rd_i;
                     op_unsigned <= unsigned_i;
                     op_reg_we   <= reg_we_i;
                     op_waddr    <= reg_waddr_i;
                     op_size     <= size_i;
                     op_index    <= index_i;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= mem_we_i;
                     bus_addr_o  <= {addr_i[31:2], 2'b00};
                     bus_be_o    <= store_be;
                     bus_wdata_o <= store_wdata;
                  end
               end
            end
            BUS: begin
               if (bus_ack_i) begin
                  state     <= IDLE;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  if (op_load) begin
                     wb_we_o    <= op_reg_we;
                     wb_waddr_o <= op_waddr;
                     wb_wdata_o <= load_data;
                  end
               end else if (timeout_cnt == TIMEOUT_LIMIT) begin
                  state       <= IDLE;
                  timeout_cnt <= 8'd0;
                  bus_req_o   <= 1'b0;
                  bus_we_o    <= 1'b0;
                  bus_err_o   <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model of the stage.
module tb_lsu_mem_stage;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        mem_rd_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] addr_i = 32'd0;
   logic [1:0]  index_i = 2'b00;
   logic [31:0] store_data_i = 32'd0;
   logic [31:0] reg_wdata_i = 32'd0;
   logic        reg_we_i = 1'b0;
   logic [4:0]  reg_waddr_i = 5'd0;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'd0;
   logic        bus_req_o, bus_we_o, wb_we_o, hold_flag_o, misalign_o, bus_err_o;
   logic [31:0] bus_addr_o, bus_wdata_o, wb_wdata_o;
   logic [3:0]  bus_be_o;
   logic [4:0]  wb_waddr_o;

   int checks = 0;
   int failures = 0;

   lsu_mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i),
      .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .index_i(index_i),
      .store_data_i(store_data_i), .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i),
      .reg_waddr_i(reg_waddr_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .wb_we_o(wb_we_o),
      .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .hold_flag_o(hold_flag_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: arithmetic rules on whole transactions ----------------
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_misaligned(input logic [1:0] size, input logic [1:0] idx);
      return (int'(idx) % nbytes(size)) != 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] idx);
      return 4'(((1 << nbytes(size)) - 1) << idx);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] sd);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % nbytes(size)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] size, input logic [1:0] idx,
                                            input logic uns, input logic [31:0] rdata);
      int n = nbytes(size);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
      logic [31:0] v = (rdata >> (8*int'(idx))) & mask;
      if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   typedef struct {
      bit         is_load;
      bit         uns;
      bit         reg_we;
      logic [4:0] waddr;
      logic [1:0] size;
      logic [1:0] idx;
   } pend_t;

   pend_t       pend;
   bit          model_live = 0;
   bit          fresh = 0;
   bit          busy = 0;
   int          waited = 0;
   logic        e_req = 0, e_we = 0, e_wb_we = 0, e_mis = 0, e_err = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_wb_wdata = 0;
   logic [3:0]  e_be = 0;
   logic [4:0]  e_wb_waddr = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         model_live = 1; fresh = 1; busy = 0; waited = 0;
         e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
         e_wb_we = 0; e_wb_waddr = 0; e_wb_wdata = 0; e_mis = 0; e_err = 0;
      end else begin
         e_wb_we = 0; e_mis = 0; e_err = 0;
         if (busy) begin
            if (bus_ack_i) begin
               busy = 0; e_req = 0;
               if (pend.is_load) begin
                  e_wb_we    = pend.reg_we;
                  e_wb_waddr = pend.waddr;
                  e_wb_wdata = exp_load(pend.size, pend.idx, pend.uns, bus_rdata_i);
               end
            end else if (waited == TIMEOUT) begin
               busy = 0; e_req = 0; e_err = 1;
            end else begin
               waited++;
            end
         end else if (valid_i) begin
            if (!(mem_rd_i || mem_we_i)) begin
               fresh = 0;
               e_wb_we = reg_we_i; e_wb_waddr = reg_waddr_i; e_wb_wdata = reg_wdata_i;
            end else if (is_misaligned(size_i, index_i)) begin
               e_mis = 1;
            end else begin
               fresh = 0; busy = 1; waited = 0;
               pend = '{is_load: mem_rd_i, uns: unsigned_i, reg_we: reg_we_i,
                        waddr: reg_waddr_i, size: size_i, idx: index_i};
               e_req = 1; e_we = mem_we_i; e_addr = {addr_i[31:2], 2'b00};
               e_be = exp_be(size_i, index_i); e_wdata = exp_wdata(size_i, store_data_i);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("hold", hold_flag_o, busy ? !bus_ack_i :
               (valid_i && (mem_rd_i || mem_we_i) && !is_misaligned(size_i, index_i)));
         check("bus_req", bus_req_o, e_req);
         if (e_req || fresh) begin
            check("bus_we", bus_we_o, e_we);
            check("bus_addr", bus_addr_o, e_addr);
            check("bus_be", bus_be_o, e_be);
            check("bus_wdata", bus_wdata_o, e_wdata);
         end
         check("wb_we", wb_we_o, e_wb_we);
         if (e_wb_we || fresh) begin
            check("wb_waddr", wb_waddr_o, e_wb_waddr);
            check("wb_wdata", wb_wdata_o, e_wb_wdata);
         end
         check("misalign", misalign_o, e_mis);
         check("bus_err", bus_err_o, e_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic rd, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd);
      valid_i = 1'b1; mem_rd_i = rd; mem_we_i = we; size_i = size; unsigned_i = uns;
      addr_i = addr; index_i = addr[1:0]; store_data_i = sd;
   endtask

   task automatic lb_test(input logic uns, input logic [31:0] exp_val);
      int holds = 0;
      set_op(1'b1, 1'b0, 2'b00, uns, 32'h0000_1003, 32'd0);
      reg_we_i = 1'b1; reg_waddr_i = 5'd9; bus_ack_i = 1'b0;
      #1 if (hold_flag_o) holds++;
      tick();
      valid_i = 1'b0;
      check("lb_addr", bus_addr_o, 32'h0000_1000);
      check("lb_be", bus_be_o, 32'h8);
      for (int i = 0; i < 2; i++) begin
         #1 if (hold_flag_o) holds++;
         tick();
      end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h80FF_0000;
      #1 if (hold_flag_o) holds++;
      tick();
      bus_ack_i = 1'b0;
      check("lb_hold_cycles", holds, 3);
      check("lb_wb_we", wb_we_o, 1);
      check("lb_wb_wdata", wb_wdata_o, exp_val);
      tick();
   endtask

   initial begin
      int n;
      repeat (3) tick();
      check("rst_req", bus_req_o, 0);
      check("rst_bus", {bus_we_o, bus_be_o, misalign_o, bus_err_o, wb_we_o}, 0);
      check("rst_addr_wdata", bus_addr_o | bus_wdata_o | wb_wdata_o | 32'(wb_waddr_o), 0);
      rst_n = 1'b1;
      tick();

      // pass-through
      valid_i = 1'b1; reg_wdata_i = 32'h1234; reg_waddr_i = 5'd5; reg_we_i = 1'b1;
      #1 check("pt_hold", hold_flag_o, 0);
      tick();
      valid_i = 1'b0;
      check("pt_wb", {wb_we_o, wb_waddr_o}, {1'b1, 5'd5});
      check("pt_wdata", wb_wdata_o, 32'h1234);
      tick();

      lb_test(1'b0, 32'hFFFF_FF80);
      lb_test(1'b1, 32'h0000_0080);

      // SH with immediate ack
      set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF);
      tick();
      valid_i = 1'b0;
      check("sh_we", bus_we_o, 1);
      check("sh_be", bus_be_o, 32'hC);
      check("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      check("sh_wb_we", wb_we_o, 0);
      tick();

      // misaligned LW and LH
      for (int k = 0; k < 2; k++) begin
         if (k == 0) set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0);
         else        set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'd0);
         #1 check("mis_hold", hold_flag_o, 0);
         tick();
         valid_i = 1'b0;
         check("mis_pulse", {bus_req_o, misalign_o, wb_we_o}, 32'b010);
         tick();
         check("mis_after", {bus_req_o, misalign_o}, 0);
      end

      // timeout
      set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0);
      bus_ack_i = 1'b0;
      tick();
      valid_i = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && bus_req_o; i++) begin
         n++;
         tick();
      end
      check("to_req_cycles", n, TIMEOUT + 1);
      check("to_err", {bus_req_o, bus_err_o}, 32'b01);
      tick();
      check("to_err_once", bus_err_o, 0);
      valid_i = 1'b1; mem_rd_i = 1'b0; reg_wdata_i = 32'hCAFE; reg_waddr_i = 5'd7; reg_we_i = 1'b1;
      tick();
      valid_i = 1'b0;
      check("to_pt", {wb_we_o, wb_waddr_o, wb_wdata_o[15:0]}, {1'b1, 5'd7, 16'hCAFE});

      // reset in the middle of an access
      set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0);
      tick();
      valid_i = 1'b0;
      check("rm_busy", bus_req_o, 1);
      rst_n = 1'b0;
      tick();
      check("rm_outputs", {bus_req_o, bus_we_o, bus_be_o, wb_we_o, misalign_o, bus_err_o}, 0);
      check("rm_addr", bus_addr_o, 0);
      rst_n = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wb_we_o || bus_err_o || bus_req_o) n++;
      end
      check("rm_ignored_ack", n, 0);
      bus_ack_i = 1'b0;

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int kind = $urandom_range(0, 2);
         logic [31:0] a = $urandom;
         valid_i      = ($urandom_range(0, 9) < 7);
         mem_rd_i     = (kind == 0);
         mem_we_i     = (kind == 1);
         size_i       = 2'($urandom_range(0, 3));
         unsigned_i   = 1'($urandom);
         addr_i       = a;
         index_i      = a[1:0];
         store_data_i = $urandom;
         reg_wdata_i  = $urandom;
         reg_we_i     = 1'($urandom);
         reg_waddr_i  = 5'($urandom);
         bus_ack_i    = ($urandom_range(0, 9) < ((i < 2000) ? 3 : 1));
         bus_rdata_i  = $urandom;
         rst_n        = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst_n = 1'b1; valid_i = 1'b0; bus_ack_i = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
